// File: rtl/demux1by8_1bit_deser.sv
// demux1by8_1bit_deser
// Sequential 1-to-8 demultiplexing deserializer. One serial bit is taken per
// din handshake and steered into a capture slot chosen by a free-running
// 3-bit slot counter. On the 8th bit the completed word is loaded into a
// registered, back-pressured output port. The slot counter is exported so a
// transmit-side 8-to-1 mux can be driven in lockstep.
//
// Configuration macro: DEMUX_BITREV_EN
//   defined   : arrival k lands in slot {k[0],k[1],k[2]} (bit-reversed)
//   undefined : arrival k lands in slot k
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   clr         in   synchronous abort of the partial frame
//   din         in   serial data bit
//   din_valid   in   din is valid this cycle
//   din_ready   out  block can accept din this cycle (combinational)
//   op[2:0]     out  slot counter = index of the next bit to be accepted
//   dout[7:0]   out  assembled word
//   dout_valid  out  dout holds an unconsumed word
//   dout_ready  in   downstream consumes dout this cycle
module demux1by8_1bit_deser (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [2:0] op,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready
);

    logic [2:0] op_q,         op_d;
    logic [7:0] cap_q,        cap_d;
    logic [7:0] dout_q,       dout_d;
    logic       dout_valid_q, dout_valid_d;
    logic [7:0] cap_merged;
    logic       accept;

    // Slot placement for the bit arriving at counter value idx.
    function automatic logic [2:0] slot_map(input logic [2:0] idx);
`ifdef DEMUX_BITREV_EN
        // op[2] is the least significant select bit on the transmit mux.
        return {idx[0], idx[1], idx[2]};
`else
        return idx;
`endif
    endfunction

    // Only the 8th bit can stall: it needs the output register free (or
    // being consumed on the same edge). Bits 0..6 only touch the capture
    // register, so they keep flowing while a finished word waits.
    assign din_ready = ~((op_q == 3'd7) & dout_valid_q & ~dout_ready);
    assign accept    = din_valid & din_ready;

    always_comb begin
        cap_merged                 = cap_q;
        cap_merged[slot_map(op_q)] = din;

        op_d         = op_q;
        cap_d        = cap_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;

        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        // clr beats a same-cycle accept; the output side is left alone.
        // Load is evaluated after consume so a simultaneous load and
        // consume keeps dout_valid high with the new word.
        if (clr) begin
            op_d  = 3'd0;
            cap_d = 8'h00;
        end else if (accept) begin
            cap_d = cap_merged;
            op_d  = op_q + 3'd1;
            if (op_q == 3'd7) begin
                dout_d       = cap_merged;
                dout_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q         <= 3'd0;
            cap_q        <= 8'h00;
            dout_q       <= 8'h00;
            dout_valid_q <= 1'b0;
        end else begin
            op_q         <= op_d;
            cap_q        <= cap_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign op         = op_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_demux1by8_1bit_deser.sv
// Testbench for demux1by8_1bit_deser. A behavioural model keeps the bits of
// the current frame in an array indexed by arrival order and builds the word
// by placing each arrival at its slot, plus a queue-free output flag/word.
module tb_demux1by8_1bit_deser;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       din;
    logic       din_valid;
    logic       din_ready;
    logic [2:0] op;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;

    int checks = 0;
    int errors = 0;

    // reference model state
    int         m_cnt;
    bit         m_bits [8];
    logic [7:0] m_dout;
    bit         m_dv;
    bit         seen_ready;
    bit         exp_ready;
    bit         accepted;

    demux1by8_1bit_deser dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .op         (op),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    always #5 clk = ~clk;

    function automatic int slot(input int k);
`ifdef DEMUX_BITREV_EN
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
`else
        return k;
`endif
    endfunction

    function automatic logic [7:0] assemble();
        logic [7:0] w;
        w = 8'h00;
        for (int k = 0; k < 8; k++) if (m_bits[k]) w = w | (8'h01 << slot(k));
        return w;
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_dv  = 0;
        m_dout = 8'h00;
        for (int k = 0; k < 8; k++) m_bits[k] = 0;
    endtask

    // One clock: drive inputs, sample din_ready before the edge, advance the
    // model, return sampling 1 time unit after the edge.
    task automatic step(input bit v, input bit d, input bit r, input bit c);
        din_valid  = v;
        din        = d;
        dout_ready = r;
        clr        = c;
        #1;
        seen_ready = din_ready;
        exp_ready  = !(m_cnt == 7 && m_dv && !r);
        accepted   = v && exp_ready && !c;
        @(posedge clk);
        #1;
        if (m_dv && r) m_dv = 0;
        if (c) begin
            m_cnt = 0;
            for (int k = 0; k < 8; k++) m_bits[k] = 0;
        end else if (v && exp_ready) begin
            m_bits[m_cnt] = d;
            if (m_cnt == 7) begin
                m_dout = assemble();
                m_dv   = 1;
                m_cnt  = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    // Sends the 8 arrivals that make word w appear on dout; optional gaps.
    task automatic send_word(input logic [7:0] w, input bit r, input bit gaps);
        logic [7:0] wv;
        int         tries;
        wv = w;
        for (int k = 0; k < 8; k++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                for (int i = 0; i < g; i++) step(0, $urandom_range(0, 1), r, 0);
            end
            tries = 0;
            do begin
                step(1, wv[slot(k)], r, 0);
                tries++;
            end while (!accepted && tries < 50);
            if (!accepted) begin
                checks++;
                errors++;
                $display("FAIL send_word_timeout: bit %0d not accepted within 50 cycles", k);
                return;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] e;
        rst = 1'b1; clr = 0; din = 0; din_valid = 0; dout_ready = 0;
        #2;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (op !== 3'd0 || dout !== 8'h00 || dout_valid !== 1'b0 || din_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_init: op=%0d dout=%h dv=%b rdy=%b expected 0 00 0 1", op, dout, dout_valid, din_ready);
        end
        // leave a word pending and a partial frame, then reset mid-frame
        send_word(8'h5C, 0, 0);
        checks++;
        if (dout !== 8'h5C || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_preword: dout=%h dv=%b expected 5c 1", dout, dout_valid);
        end
        for (int k = 0; k < 3; k++) step(1, 1, 0, 0);
        rst = 1'b1;
        #2;
        model_reset();
        checks++;
        if (op !== 3'd0 || dout !== 8'h00 || dout_valid !== 1'b0 || din_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_midframe: op=%0d dout=%h dv=%b rdy=%b expected 0 00 0 1", op, dout, dout_valid, din_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        send_word(8'hC3, 1, 0);
        e = 8'hC3;
        checks++;
        if (dout !== e || dout_valid !== 1'b1 || m_dout !== e) begin
            errors++;
            $display("FAIL reset_fresh_word: dout=%h dv=%b expected %h 1", dout, dout_valid, e);
        end
        step(0, 0, 1, 0);
    endtask

    task automatic test_stream();
        bit         pat [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
        logic [7:0] e;
`ifdef DEMUX_BITREV_EN
        e = 8'h11;
`else
        e = 8'h03;
`endif
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (op !== 3'(k)) begin
                errors++;
                $display("FAIL stream_op: k=%0d op=%0d expected %0d", k, op, k);
            end
            step(1, pat[k], 1, 0);
        end
        checks++;
        if (dout !== e || dout_valid !== 1'b1 || op !== 3'd0 || m_dout !== e) begin
            errors++;
            $display("FAIL stream_word: dout=%h dv=%b op=%0d expected %h 1 0", dout, dout_valid, op, e);
        end
        step(0, 0, 1, 0);
        checks++;
        if (dout_valid !== 1'b0 || dout !== e) begin
            errors++;
            $display("FAIL stream_pulse: dv=%b dout=%h expected 0 %h", dout_valid, dout, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w2;
        w2 = 8'h5A;
        send_word(8'hA5, 0, 0);
        checks++;
        if (dout !== 8'hA5 || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_first: dout=%h dv=%b expected a5 1", dout, dout_valid);
        end
        for (int k = 0; k < 7; k++) begin
            step(1, w2[slot(k)], 0, 0);
            checks++;
            if (seen_ready !== 1'b1 || dout !== 8'hA5) begin
                errors++;
                $display("FAIL bp_early_bits: k=%0d rdy=%b dout=%h expected 1 a5", k, seen_ready, dout);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1, w2[slot(7)], 0, 0);
            checks++;
            if (seen_ready !== 1'b0 || op !== 3'd7 || dout !== 8'hA5 || dout_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_stall: rdy=%b op=%0d dout=%h dv=%b expected 0 7 a5 1", seen_ready, op, dout, dout_valid);
            end
        end
        step(1, w2[slot(7)], 1, 0);
        checks++;
        if (seen_ready !== 1'b1 || dout_valid !== 1'b1 || dout !== 8'h5A || op !== 3'd0) begin
            errors++;
            $display("FAIL bp_load_consume: rdy=%b dv=%b dout=%h op=%0d expected 1 1 5a 0", seen_ready, dout_valid, dout, op);
        end
        step(0, 0, 1, 0);
        checks++;
        if (dout_valid !== 1'b0 || dout !== 8'h5A) begin
            errors++;
            $display("FAIL bp_drain: dv=%b dout=%h expected 0 5a", dout_valid, dout);
        end
    endtask

    task automatic test_clr();
        send_word(8'h96, 0, 0);
        for (int k = 0; k < 5; k++) step(1, 1, 0, 0);
        checks++;
        if (op !== 3'd5) begin
            errors++;
            $display("FAIL clr_pre_op: op=%0d expected 5", op);
        end
        step(1, 1, 0, 1);
        checks++;
        if (op !== 3'd0 || dout !== 8'h96 || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL clr_abort: op=%0d dout=%h dv=%b expected 0 96 1", op, dout, dout_valid);
        end
        step(0, 0, 1, 0);
        send_word(8'h21, 1, 0);
        checks++;
        if (dout !== 8'h21 || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL clr_next_word: dout=%h dv=%b expected 21 1", dout, dout_valid);
        end
        step(0, 0, 1, 0);
    endtask

    task automatic test_gaps();
        logic [7:0] wv;
        int         held;
        wv = 8'h3C;
        for (int k = 0; k < 8; k++) begin
            int g;
            g = $urandom_range(1, 3);
            for (int i = 0; i < g; i++) begin
                held = k;
                step(0, $urandom_range(0, 1), 1, 0);
                checks++;
                if (op !== 3'(held)) begin
                    errors++;
                    $display("FAIL gap_op_hold: op=%0d expected %0d", op, held);
                end
            end
            step(1, wv[slot(k)], 1, 0);
        end
        checks++;
        if (dout !== 8'h3C || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL gap_word: dout=%h dv=%b expected 3c 1", dout, dout_valid);
        end
        step(0, 0, 1, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                 $urandom_range(0, 1) != 0, $urandom_range(0, 31) == 0);
            checks++;
            if (seen_ready !== exp_ready || op !== 3'(m_cnt) || dout_valid !== m_dv || dout !== m_dout) begin
                errors++;
                $display("FAIL random_cycle %0d: rdy=%b op=%0d dv=%b dout=%h expected %b %0d %b %h",
                         n, seen_ready, op, dout_valid, dout, exp_ready, m_cnt, m_dv, m_dout);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_clr();
        test_gaps();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

endmodule
